div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//  Multi-cycle sequencer for DIV/DIVU in EX. Accepts operands from EX, runs a WIDTH-iteration
//  restoring division, holds the pipeline through stallreq_o, then returns {remainder,quotient}
//  for the HI/LO write path. One division in flight; EX holds start_i until ready_o.
// PARAMETERS
//  WIDTH  32  operand width; result is 2*WIDTH; iteration count = WIDTH
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        reset, synchronous, active-high
//  start_i      in   1        request division (level, held by EX until ready_o)
//  annul_i      in   1        abort current/pending division (flush)
//  signed_i     in   1        1 = DIV (two's complement), 0 = DIVU
//  opdata1_i    in   WIDTH    dividend
//  opdata2_i    in   WIDTH    divisor
//  result_o     out  2*WIDTH  {remainder, quotient}; valid while ready_o=1
//  ready_o      out  1        result valid
//  stallreq_o   out  1        stall request to pipeline control
// BEHAVIOUR
//  - Reset: state=IDLE, result_o=0, ready_o=0, iteration counter=0, internal regs=0.
//  - States: IDLE, ZERO, ON, END (2-bit encoding; constants in defines.v).
//  - IDLE: start_i & ~annul_i & divisor==0 -> ZERO; start_i & ~annul_i & divisor!=0 -> ON, latch
//    |dividend|,|divisor| (abs only if signed_i), latch signed_i and operand signs, counter=0.
//  - ZERO: next cycle -> END with result_o=0.
//  - ON: one quotient bit per cycle, MSB first; counter++; after WIDTH iterations -> END.
//  - END: result_o registered, ready_o=1; stays END while start_i=1; start_i=0 -> IDLE, ready_o=0.
//  - Sign fix on ON->END: quotient negated if dividend sign != divisor sign; remainder negated if
//    dividend negative (truncation toward zero). Unsigned: no fix. MIN/-1: quotient=MIN, rem=0.
//  - stallreq_o (combinational) = (IDLE & start_i & ~annul_i) | ZERO | ON. Low in END.
//  - Latency, divisor!=0: start seen cycle 0, ON cycles 1..WIDTH, ready_o cycle WIDTH+1;
//    stall WIDTH+1 cycles. Divisor==0: ready_o cycle 2, stall 2 cycles.
//  - annul_i in ON or ZERO: -> IDLE next cycle, ready_o stays 0, stallreq_o drops same cycle.
//  - annul_i in END: -> IDLE. annul_i wins over start_i in every state.
//  - Operand changes during ON/ZERO/END are ignored (latched at IDLE).
//  - rst mid-operation: -> IDLE with all reset values next edge; no partial result visible.
// CONFIGURATION
//  DIV_ZERO_FLAG_EN defined: extra output div_zero_o (1 bit), set with ready_o when the division
//    went through ZERO, cleared on leaving END or on rst/annul_i; reset 0.
//  Not defined: port absent; divide-by-zero only distinguishable as result_o=0.
// STRUCTURE
//  - defines.v: DivFree/DivByZero/DivOn/DivEnd state codes, DivResultReady/NotReady,
//    DivStart/DivStop, DoubleRegBus width macro.
//  - No sub-module: single file; iteration step (subtract/compare/shift) inline in ON.
// TESTING
//  1 DIVU 100/7: ready_o at cycle 33, result_o={32'd2,32'd14}; stallreq_o high cycles 0..32.
//  2 DIV -7/2: quotient 0xFFFF_FFFD (-3), remainder 0xFFFF_FFFF (-1); 7/-2 -> q=-3, r=1.
//  3 Divisor 0 (any dividend): ready_o at cycle 2, result_o=0, div_zero_o=1 with macro.
//  4 DIV 0x8000_0000 / 0xFFFF_FFFF: q=0x8000_0000, r=0; DIVU 0xFFFF_FFFF/1: q=0xFFFF_FFFF, r=0.
//  5 annul_i at cycle 10 of ON: IDLE next cycle, ready_o never asserts, new start runs cleanly.
//  6 start_i held 3 cycles in END: ready_o/result_o stable; start_i=0 -> IDLE; rst in ON -> IDLE.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared state codes and control constants for the sequential divider.
// Optional divide-by-zero flag is enabled by defining DIV_ZERO_FLAG_EN.
package div_seq_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned DoubleRegBus = 2 * DefaultWidth;

endpackage

// File: rtl/div_seq_if.sv
// EX <-> divider handshake bundle; master is the EX stage, slave is div_seq.
// div_zero_o exists only when DIV_ZERO_FLAG_EN is defined.
interface div_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic               start_i;
    logic               annul_i;
    logic               signed_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               stallreq_o;
`ifdef DIV_ZERO_FLAG_EN
    logic               div_zero_o;

    modport master (
        output start_i, annul_i, signed_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, stallreq_o, div_zero_o
    );
    modport slave (
        input  start_i, annul_i, signed_i, opdata1_i, opdata2_i,
        output result_o, ready_o, stallreq_o, div_zero_o
    );
`else
    modport master (
        output start_i, annul_i, signed_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, stallreq_o
    );
    modport slave (
        input  start_i, annul_i, signed_i, opdata1_i, opdata2_i,
        output result_o, ready_o, stallreq_o
    );
`endif
endinterface

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle, result {rem, quo}.
// Define DIV_ZERO_FLAG_EN to add the div_zero_o flag on the interface.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input logic      clk,
    input logic      rst,
    div_seq_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    div_state_e         state;
    logic [WIDTH-1:0]   divisor_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [CntW-1:0]    cnt_q;
    logic               sign_q;
    logic               neg_dvd_q;
    logic               neg_dvs_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;
`ifdef DIV_ZERO_FLAG_EN
    logic               div_zero_q;
`endif

    logic               go;
    logic [WIDTH-1:0]   abs_dvd;
    logic [WIDTH-1:0]   abs_dvs;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   step_r;
    logic [WIDTH-1:0]   step_q;
    logic [WIDTH-1:0]   fix_r;
    logic [WIDTH-1:0]   fix_q;
    logic               last_iter;

    always_comb begin
        go      = bus.start_i & ~bus.annul_i;
        abs_dvd = (bus.signed_i & bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
        abs_dvs = (bus.signed_i & bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;
        // Shift next dividend bit into the partial remainder and try subtracting the divisor.
        trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, divisor_q};
        step_r  = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
        step_q  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        // Truncation toward zero: remainder takes the dividend's sign.
        fix_q   = (sign_q & (neg_dvd_q ^ neg_dvs_q)) ? -step_q : step_q;
        fix_r   = (sign_q & neg_dvd_q) ? -step_r : step_r;
        last_iter = (cnt_q == CntW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DivFree;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            neg_dvd_q <= 1'b0;
            neg_dvs_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            case (state)
                DivFree: begin
                    if (go) begin
                        if (bus.opdata2_i == '0) begin
                            state <= DivByZero;
                        end else begin
                            state     <= DivOn;
                            divisor_q <= abs_dvs;
                            quo_q     <= abs_dvd;
                            rem_q     <= '0;
                            cnt_q     <= '0;
                            sign_q    <= bus.signed_i;
                            neg_dvd_q <= bus.signed_i & bus.opdata1_i[WIDTH-1];
                            neg_dvs_q <= bus.signed_i & bus.opdata2_i[WIDTH-1];
                        end
                    end
                end
                DivByZero: begin
                    if (bus.annul_i) begin
                        state <= DivFree;
                    end else begin
                        state    <= DivEnd;
                        result_q <= '0;
                        ready_q  <= DivResultReady;
`ifdef DIV_ZERO_FLAG_EN
                        div_zero_q <= 1'b1;
`endif
                    end
                end
                DivOn: begin
                    if (bus.annul_i) begin
                        state <= DivFree;
                    end else begin
                        rem_q <= step_r;
                        quo_q <= step_q;
                        cnt_q <= cnt_q + CntW'(1);
                        if (last_iter) begin
                            state    <= DivEnd;
                            result_q <= {fix_r, fix_q};
                            ready_q  <= DivResultReady;
                        end
                    end
                end
                DivEnd: begin
                    if (bus.annul_i || (bus.start_i == DivStop)) begin
                        state    <= DivFree;
                        result_q <= '0;
                        ready_q  <= DivResultNotReady;
`ifdef DIV_ZERO_FLAG_EN
                        div_zero_q <= 1'b0;
`endif
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

    // Stall drops in the same cycle an annul arrives, before the state moves.
    assign bus.stallreq_o = ((state == DivFree) & go)
                          | (((state == DivByZero) | (state == DivOn)) & ~bus.annul_i);
    assign bus.result_o   = result_q;
    assign bus.ready_o    = ready_q;
`ifdef DIV_ZERO_FLAG_EN
    assign bus.div_zero_o = div_zero_q;
`endif

endmodule

// File: tb/tb_div_seq.sv
// Randomized self-checking bench for div_seq against a plain-arithmetic division model.
// Define DIV_ZERO_FLAG_EN to also check div_zero_o.
module tb_div_seq;

    localparam int unsigned W = 32;

    logic clk;
    logic rst;
    div_seq_if #(.WIDTH(W)) bus ();

    div_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic         chk_en;
    logic         exp_stall;
    logic         exp_ready;
    logic         exp_dz;
    logic [63:0]  exp_res;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero; divide-by-zero gives 0.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (!s) return {a % b, a / b};
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stallreq", {63'd0, bus.stallreq_o}, {63'd0, exp_stall});
            chk("ready", {63'd0, bus.ready_o}, {63'd0, exp_ready});
            if (exp_ready) chk("result", bus.result_o, exp_res);
`ifdef DIV_ZERO_FLAG_EN
            chk("div_zero", {63'd0, bus.div_zero_o}, {63'd0, exp_dz});
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        exp_stall = 1'b0;
        exp_ready = 1'b0;
        exp_dz    = 1'b0;
    endtask

    // Drives one division; cycle k counts from the cycle start_i is first seen.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int annul_at, input int hold, input logic use_lit,
                          input logic [63:0] lit);
        int          lat;
        logic [63:0] want;
        lat  = (b == 32'd0) ? 2 : W + 1;
        want = model(a, b, s);
        if (use_lit) begin
            chk("model_pin", want, lit);
            want = lit;
        end
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        bus.signed_i  = s;
        bus.annul_i   = 1'b0;
        bus.start_i   = 1'b1;
        for (int k = 0; k < lat + hold; k++) begin
            if (k == annul_at) begin
                bus.annul_i = 1'b1;
                set_idle();
                tick();
                bus.annul_i = 1'b0;
                bus.start_i = 1'b0;
                tick();
                return;
            end
            if (k >= 1) begin
                bus.opdata1_i = $urandom;
                bus.opdata2_i = $urandom;
                bus.signed_i  = $urandom_range(0, 1) == 1;
            end
            exp_stall = (k < lat);
            exp_ready = (k >= lat);
            exp_dz    = exp_ready && (b == 32'd0);
            exp_res   = want;
            tick();
        end
        bus.start_i = 1'b0;
        exp_stall   = 1'b0;
        tick();
        set_idle();
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic        s;
        int          mode, ann, lat;

        chk_en        = 1'b0;
        bus.start_i   = 1'b0;
        bus.annul_i   = 1'b0;
        bus.signed_i  = 1'b0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        set_idle();
        exp_res = '0;
        rst     = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_result", bus.result_o, 64'd0);
        tick();

        run_op(32'd100, 32'd7, 1'b0, -1, 1, 1'b1, {32'd2, 32'd14});
        run_op(-32'sd7, 32'd2, 1'b1, -1, 1, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(32'd7, -32'sd2, 1'b1, -1, 1, 1'b1, {32'd1, 32'hFFFF_FFFD});
        run_op(32'h1234_5678, 32'd0, 1'b1, -1, 1, 1'b1, 64'd0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, 1, 1'b1, {32'd0, 32'h8000_0000});
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, -1, 1, 1'b1, {32'd0, 32'hFFFF_FFFF});
        run_op(32'd1000, 32'd9, 1'b0, 10, 1, 1'b0, 64'd0);
        run_op(32'd1000, 32'd9, 1'b0, -1, 1, 1'b1, {32'd1, 32'd111});
        run_op(32'd0, 32'd0, 1'b0, 1, 1, 1'b0, 64'd0);
        run_op(-32'sd100, -32'sd7, 1'b1, -1, 3, 1'b1, {32'hFFFF_FFFE, 32'd14});

        // Reset in the middle of an iteration sequence.
        bus.opdata1_i = 32'd500;
        bus.opdata2_i = 32'd3;
        bus.signed_i  = 1'b0;
        bus.start_i   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_stall = 1'b1;
            exp_ready = 1'b0;
            tick();
        end
        chk_en      = 1'b0;
        rst         = 1'b1;
        bus.start_i = 1'b0;
        tick();
        rst    = 1'b0;
        set_idle();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_mid_result", bus.result_o, 64'd0);
        tick();
        tick();

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 5);
            a    = $urandom;
            b    = $urandom;
            s    = $urandom_range(0, 1) == 1;
            if (mode == 0) b = 32'd0;
            else if (mode == 1) b = $urandom_range(1, 15);
            else if (mode == 2) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
                s = 1'b1;
            end
            lat = (b == 32'd0) ? 2 : W + 1;
            ann = ($urandom_range(0, 5) == 0) ? $urandom_range(1, lat - 1) : -1;
            run_op(a, b, s, ann, $urandom_range(1, 3), 1'b0, 64'd0);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
